axil_dice_bank: RTL and testbench

//  Parametrised AXI4-Lite slave holding NUM_DICE independent dice. Each die rolls for a pseudo-random number of cycles, then settles on a value 1..FACES.

---
 rtl/axil_dice_pkg.sv | 29 ++
 rtl/axil_dice_bank_if.sv | 43 ++++
 rtl/axil_dice_die.sv | 48 ++++
 rtl/axil_dice_bank.sv | 195 +++++++++++++++++++
 tb/tb_axil_dice_bank.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_dice_pkg.sv
// ============================================================================
// axil_dice_pkg : shared constants, types and LFSR step for the dice bank
// Revision: 1.0
// ============================================================================
`default_nettype none

package axil_dice_pkg;

  localparam int unsigned OFF_CTRL     = 32'h00;
  localparam int unsigned OFF_STATUS   = 32'h04;
  localparam int unsigned OFF_SEED     = 32'h08;
  localparam int unsigned OFF_IRQ_STAT = 32'h0C;
  localparam int unsigned OFF_RESULT0  = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef logic [3:0] die_val_t;

  // Right-shifting Galois step: the tap mask is folded in when bit 0 falls out
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_dice_bank_if.sv
// ============================================================================
// axil_dice_bank_if : AXI4-Lite bundle with master/slave modports
// Revision: 1.0
// ============================================================================
`default_nettype none

interface axil_dice_bank_if #(
  parameter int ADDR_WIDTH = 6
) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/axil_dice_die.sv
// ============================================================================
// axil_dice_die : one die - value stepper, roll counter, busy flag, done pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module axil_dice_die
  import axil_dice_pkg::*;
#(
  parameter int FACES = 6,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load,
  output die_val_t         value,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // A restart while busy reloads the counter, so it must not count as completion
  assign done = busy && !start && (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= die_val_t'(1);
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      if (busy)
        value <= (value == die_val_t'(FACES)) ? die_val_t'(1) : die_val_t'(value + 4'd1);
      if (start) begin
        cnt  <= load;
        busy <= 1'b1;
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1))
          busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axil_dice_bank.sv
// ============================================================================
// axil_dice_bank : AXI4-Lite bank of NUM_DICE LFSR-timed dice
// Optional level interrupt on roll completion: define AXIL_DICE_IRQ_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module axil_dice_bank
  import axil_dice_pkg::*;
#(
  parameter int NUM_DICE    = 4,
  parameter int FACES       = 6,
  parameter int ROLL_CYCLES = 16,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axil_dice_bank_if.slave       s_axi,
  output logic [NUM_DICE*4-1:0] die_value,
  output logic [NUM_DICE-1:0]   die_busy
`ifdef AXIL_DICE_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int unsigned WORD_CTRL     = OFF_CTRL / 4;
  localparam int unsigned WORD_STATUS   = OFF_STATUS / 4;
  localparam int unsigned WORD_SEED     = OFF_SEED / 4;
  localparam int unsigned WORD_IRQ_STAT = OFF_IRQ_STAT / 4;
  localparam int unsigned WORD_RESULT0  = OFF_RESULT0 / 4;
  localparam int unsigned WORD_END      = WORD_RESULT0 + NUM_DICE;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACCEPT = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACCEPT = 2'd1, R_RESP = 2'd2} rd_state_t;

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic [31:0]           lfsr;
  logic [31:0]           aw_word;
  logic [31:0]           ar_word;
  logic                  wr_fire;
  logic                  wr_ok;
  logic [NUM_DICE-1:0]   start;
  logic [NUM_DICE-1:0]   done_pulse;
  logic [31:0]           rd_data;
  logic                  rd_ok;
  logic                  unused_bits;

  assign aw_word = 32'(s_axi.awaddr[ADDR_WIDTH-1:2]);
  assign ar_word = 32'(s_axi.araddr[ADDR_WIDTH-1:2]);
  assign wr_fire = (wr_state == W_ACCEPT);
  assign wr_ok   = (aw_word < WORD_END);
  assign start   = (wr_fire && aw_word == WORD_CTRL) ? s_axi.wdata[NUM_DICE-1:0] : '0;

  // Write path: AW and W are only ever accepted together
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state      <= W_IDLE;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: if (s_axi.awvalid && s_axi.wvalid) begin
          s_axi.awready <= 1'b1;
          s_axi.wready  <= 1'b1;
          wr_state      <= W_ACCEPT;
        end
        W_ACCEPT: begin
          s_axi.awready <= 1'b0;
          s_axi.wready  <= 1'b0;
          s_axi.bvalid  <= 1'b1;
          s_axi.bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          wr_state      <= W_RESP;
        end
        W_RESP: if (s_axi.bready) begin
          s_axi.bvalid <= 1'b0;
          wr_state     <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state      <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: if (s_axi.arvalid) begin
          s_axi.arready <= 1'b1;
          rd_state      <= R_ACCEPT;
        end
        R_ACCEPT: begin
          s_axi.arready <= 1'b0;
          s_axi.rvalid  <= 1'b1;
          s_axi.rdata   <= rd_data;
          s_axi.rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          rd_state      <= R_RESP;
        end
        R_RESP: if (s_axi.rready) begin
          s_axi.rvalid <= 1'b0;
          rd_state     <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      lfsr <= 32'h1;
    else if (wr_fire && aw_word == WORD_SEED)
      lfsr <= (s_axi.wdata == 32'h0) ? 32'h1 : s_axi.wdata;
    else
      lfsr <= lfsr_next(lfsr);
  end

`ifdef AXIL_DICE_IRQ_EN
  logic [NUM_DICE-1:0] done_flags;
  logic [NUM_DICE-1:0] done_clr;

  assign done_clr = (wr_fire && aw_word == WORD_IRQ_STAT) ? s_axi.wdata[NUM_DICE-1:0] : '0;
  assign irq      = |done_flags;

  // OR-ing the new pulse in after the clear lets a same-cycle completion win
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      done_flags <= '0;
    else
      done_flags <= (done_flags & ~done_clr) | done_pulse;
  end
`endif

  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b1;
    case (ar_word)
      WORD_CTRL:     rd_data = '0;
      WORD_STATUS:   rd_data = 32'(die_busy);
      WORD_SEED:     rd_data = lfsr;
`ifdef AXIL_DICE_IRQ_EN
      WORD_IRQ_STAT: rd_data = 32'(done_flags);
`else
      WORD_IRQ_STAT: rd_data = '0;
`endif
      default: begin
        rd_ok = 1'b0;
        for (int i = 0; i < NUM_DICE; i++) begin
          if (ar_word == WORD_RESULT0 + i) begin
            rd_ok   = 1'b1;
            rd_data = {28'b0, die_value[4*i +: 4]};
          end
        end
      end
    endcase
  end

  for (genvar i = 0; i < NUM_DICE; i++) begin : g_die
    localparam int LO = (4 * i) % 32;
    logic [8:0] load;

    assign load = 9'(ROLL_CYCLES) + 9'(lfsr[LO +: 4]);

    axil_dice_die #(
      .FACES (FACES),
      .CNT_W (9)
    ) u_die (
      .clk   (ACLK),
      .rst   (ARESET),
      .start (start[i]),
      .load  (load),
      .value (die_value[4*i +: 4]),
      .busy  (die_busy[i]),
      .done  (done_pulse[i])
    );
  end

`ifdef AXIL_DICE_IRQ_EN
  assign unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.awprot,
                         s_axi.arprot, s_axi.wstrb};
`else
  assign unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.awprot,
                         s_axi.arprot, s_axi.wstrb, done_pulse};
`endif

endmodule

`default_nettype wire

// File: tb/tb_axil_dice_bank.sv
// ============================================================================
// tb_axil_dice_bank : scoreboard-driven bench for the AXI4-Lite dice bank
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axil_dice_bank;
  import axil_dice_pkg::*;

  localparam int NUM_DICE    = 4;
  localparam int FACES       = 6;
  localparam int ROLL_CYCLES = 16;
  localparam int AW          = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_dice_bank_if #(.ADDR_WIDTH(AW)) bus ();
  logic [NUM_DICE*4-1:0] die_value;
  logic [NUM_DICE-1:0]   die_busy;
`ifdef AXIL_DICE_IRQ_EN
  logic irq;
`endif

  axil_dice_bank #(
    .NUM_DICE    (NUM_DICE),
    .FACES       (FACES),
    .ROLL_CYCLES (ROLL_CYCLES),
    .ADDR_WIDTH  (AW)
  ) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .s_axi     (bus.slave),
    .die_value (die_value),
    .die_busy  (die_busy)
`ifdef AXIL_DICE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  int asserts  = 0;
  int failures = 0;
  logic [33:0] exp_q[$];
  int ev[NUM_DICE];

  // Reference LFSR plus handshake bookkeeping
  logic [31:0] cyc = 0;
  logic [31:0] m_lfsr = 32'h1;
  logic [31:0] aw_cyc = 0, aw_lfsr = 0, ar_lfsr = 0;
  int aw_accepts = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m_lfsr <= 32'h1;
    else if (bus.awvalid && bus.awready && bus.awaddr[AW-1:2] == 4'h2)
      m_lfsr <= (bus.wdata == 32'h0) ? 32'h1 : bus.wdata;
    else
      m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
    if (bus.awvalid && bus.awready) begin
      aw_cyc <= cyc; aw_lfsr <= m_lfsr; aw_accepts <= aw_accepts + 1;
    end
    if (bus.arvalid && bus.arready) ar_lfsr <= m_lfsr;
  end

  function automatic int step(input int v, input int n);
    return ((v - 1 + n) % FACES) + 1;
  endfunction

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    bus.awaddr = addr; bus.wdata = data; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    if (!bus.awready) begin
      asserts++; failures++;
      $display("FAIL aw_timeout: awready=%0b required 1", bus.awready);
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0; @(negedge clk);
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.bvalid) begin
      asserts++; failures++;
      $display("FAIL b_timeout: bvalid=%0b required 1", bus.bvalid);
    end
    resp = bus.bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    bus.araddr = addr; bus.arvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    if (!bus.arready) begin
      asserts++; failures++;
      $display("FAIL ar_timeout: arready=%0b required 1", bus.arready);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0; @(negedge clk);
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.rvalid) begin
      asserts++; failures++;
      $display("FAIL r_timeout: rvalid=%0b required 1", bus.rvalid);
    end
    data = bus.rdata; resp = bus.rresp;
    @(posedge clk); #1;
  endtask

  task automatic wait_fall(input int die, output logic [31:0] fall);
    int n;
    n = 0; @(negedge clk);
    while (die_busy[die] && n < 400) begin @(negedge clk); n++; end
    fall = cyc;
    if (die_busy[die]) begin
      asserts++; failures++;
      $display("FAIL busy_timeout die%0d: busy=%0b required 0", die, die_busy[die]);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; logic [33:0] e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    asserts++;
    if ({die_busy, die_value, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== {4'h0, 16'h1111, 5'b0}) begin
      failures++;
      $display("FAIL reset_outputs: busy=%h value=%h awr=%b wr=%b bv=%b arr=%b rv=%b required busy=0 value=1111 rest 0",
               die_busy, die_value, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid);
    end
    asserts++;
    if ({bus.rdata, bus.bresp, bus.rresp} !== 36'h0) begin
      failures++;
      $display("FAIL reset_data: rdata=%h bresp=%b rresp=%b required 0", bus.rdata, bus.bresp, bus.rresp);
    end
    exp_q.push_back({RESP_OKAY, 32'h0});
    exp_q.push_back({RESP_OKAY, 32'h1});
    axi_read(6'h04, d, r); e = exp_q.pop_front(); asserts++;
    if ({r, d} !== e) begin failures++; $display("FAIL status_reset: got %h required %h", {r, d}, e); end
    axi_read(6'h10, d, r); e = exp_q.pop_front(); asserts++;
    if ({r, d} !== e) begin failures++; $display("FAIL result0_reset: got %h required %h", {r, d}, e); end
    axi_read(6'h08, d, r); asserts++;
    if (d === 32'h0 || d !== ar_lfsr || r !== RESP_OKAY) begin
      failures++; $display("FAIL seed_read: got %h resp %b required %h (nonzero) resp 00", d, r, ar_lfsr);
    end
  endtask

  task automatic test_single_roll();
    logic [31:0] d, fall; logic [1:0] r; logic [33:0] e; int n;
    axi_write(6'h08, 32'h0, r);
    axi_write(6'h00, 32'h1, r);
    n = ROLL_CYCLES + int'(aw_lfsr[3:0]);
    wait_fall(0, fall); asserts++;
    if (fall - aw_cyc - 1 !== 32'(n)) begin
      failures++; $display("FAIL busy_len die0: got %0d required %0d", fall - aw_cyc - 1, n);
    end
    ev[0] = step(ev[0], n);
    exp_q.push_back({RESP_OKAY, 32'(ev[0])});
    exp_q.push_back({RESP_OKAY, 32'h0});
    axi_read(6'h10, d, r); e = exp_q.pop_front(); asserts++;
    if ({r, d} !== e || d < 1 || d > FACES) begin
      failures++; $display("FAIL result0_roll: got %h required %h", {r, d}, e);
    end
    axi_read(6'h04, d, r); e = exp_q.pop_front(); asserts++;
    if ({r, d} !== e) begin failures++; $display("FAIL status_idle: got %h required %h", {r, d}, e); end
  endtask

  task automatic test_restart();
    logic [31:0] d, t0, l0, t1, l1; logic [1:0] r; logic [33:0] e;
    logic [31:0] fall[NUM_DICE]; int n;
    axi_write(6'h00, 32'hF, r); t0 = aw_cyc; l0 = aw_lfsr;
    axi_write(6'h00, 32'h1, r); t1 = aw_cyc; l1 = aw_lfsr;
    for (int i = 0; i < NUM_DICE; i++) fall[i] = 0;
    n = 0;
    while (die_busy != 0 && n < 400) begin
      @(negedge clk); n++;
      for (int i = 0; i < NUM_DICE; i++) if (fall[i] == 0 && !die_busy[i]) fall[i] = cyc;
    end
    for (int i = 0; i < NUM_DICE; i++) begin
      int len, steps; logic [31:0] ref_t;
      len   = ROLL_CYCLES + int'((i == 0) ? l1[3:0] : l0[4*i +: 4]);
      ref_t = (i == 0) ? t1 : t0;
      steps = (i == 0) ? int'(t1 - t0) + len : len;
      asserts++;
      if (fall[i] - ref_t - 1 !== 32'(len)) begin
        failures++; $display("FAIL restart_len die%0d: got %0d required %0d", i, fall[i] - ref_t - 1, len);
      end
      ev[i] = step(ev[i], steps);
      exp_q.push_back({RESP_OKAY, 32'(ev[i])});
    end
    for (int i = 0; i < NUM_DICE; i++) begin
      axi_read(AW'(16 + 4 * i), d, r); e = exp_q.pop_front(); asserts++;
      if ({r, d} !== e) begin failures++; $display("FAIL restart_value die%0d: got %h required %h", i, {r, d}, e); end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r; logic [33:0] e;
    exp_q.push_back({RESP_SLVERR, 32'h0});
    axi_read(6'h3C, d, r); e = exp_q.pop_front(); asserts++;
    if ({r, d} !== e) begin failures++; $display("FAIL unmapped_read: got %h required %h", {r, d}, e); end
    axi_write(6'h3C, 32'h1234, r); asserts++;
    if (r !== RESP_SLVERR) begin failures++; $display("FAIL unmapped_write: bresp=%b required 10", r); end
    axi_write(6'h14, 32'hAAAA5555, r); asserts++;
    if (r !== RESP_OKAY) begin failures++; $display("FAIL ro_write: bresp=%b required 00", r); end
    exp_q.push_back({RESP_OKAY, 32'(ev[1])});
    axi_read(6'h14, d, r); e = exp_q.pop_front(); asserts++;
    if ({r, d} !== e) begin failures++; $display("FAIL ro_unchanged: got %h required %h", {r, d}, e); end
  endtask

  task automatic test_back_to_back();
    int acc0, n;
    // read held by RREADY low
    bus.rready = 1'b0;
    @(posedge clk); #1; bus.araddr = 6'h10; bus.arvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1; bus.arvalid = 1'b0;
    repeat (5) begin
      @(negedge clk); asserts++;
      if (!bus.rvalid || bus.rdata !== 32'(ev[0]) || bus.rresp !== RESP_OKAY) begin
        failures++; $display("FAIL r_stall: rvalid=%b rdata=%h required 1 %h", bus.rvalid, bus.rdata, ev[0]);
      end
    end
    bus.rready = 1'b1; @(posedge clk); @(negedge clk); asserts++;
    if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL r_release: rvalid=%b required 0", bus.rvalid); end
    // write held by BREADY low
    bus.bready = 1'b0;
    @(posedge clk); #1; bus.awaddr = 6'h00; bus.wdata = 32'h0; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    repeat (5) begin
      @(negedge clk); asserts++;
      if (!bus.bvalid || bus.bresp !== RESP_OKAY) begin
        failures++; $display("FAIL b_stall: bvalid=%b bresp=%b required 1 00", bus.bvalid, bus.bresp);
      end
    end
    bus.bready = 1'b1; @(posedge clk); @(negedge clk); asserts++;
    if (bus.bvalid !== 1'b0) begin failures++; $display("FAIL b_release: bvalid=%b required 0", bus.bvalid); end
    // AW three cycles ahead of W
    acc0 = aw_accepts;
    @(posedge clk); #1; bus.awaddr = 6'h00; bus.wdata = 32'h0; bus.awvalid = 1'b1;
    repeat (3) begin
      @(negedge clk); asserts++;
      if (bus.awready !== 1'b0) begin failures++; $display("FAIL lone_aw: awready=%b required 0", bus.awready); end
    end
    bus.wvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    repeat (6) @(negedge clk);
    asserts++;
    if (aw_accepts !== acc0 + 1) begin failures++; $display("FAIL split_accept: got %0d required %0d", aw_accepts - acc0, 1); end
  endtask

  task automatic test_reset_mid_roll();
    logic [1:0] r;
    axi_write(6'h00, 32'h2, r);
    repeat (3) @(negedge clk);
    rst = 1'b1; #1; asserts++;
    if (die_busy !== 4'h0 || die_value !== 16'h1111) begin
      failures++; $display("FAIL async_reset: busy=%h value=%h required 0 1111", die_busy, die_value);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NUM_DICE; i++) ev[i] = 1;
`ifdef AXIL_DICE_IRQ_EN
    asserts++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: irq=%b required 0", irq); end
`endif
  endtask

  task automatic test_irq();
    logic [31:0] d; logic [1:0] r; logic [33:0] e;
`ifdef AXIL_DICE_IRQ_EN
    logic [31:0] fall; int n;
    axi_write(6'h00, 32'h4, r);
    n = ROLL_CYCLES + int'(aw_lfsr[11:8]);
    wait_fall(2, fall); asserts++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set: irq=%b required 1", irq); end
    ev[2] = step(ev[2], n);
    exp_q.push_back({RESP_OKAY, 32'h4});
    axi_read(6'h0C, d, r); e = exp_q.pop_front(); asserts++;
    if ({r, d} !== e) begin failures++; $display("FAIL irq_stat: got %h required %h", {r, d}, e); end
    axi_write(6'h0C, 32'h4, r); asserts++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: irq=%b required 0", irq); end
`else
    axi_write(6'h0C, 32'hF, r); asserts++;
    if (r !== RESP_OKAY) begin failures++; $display("FAIL irq_stat_write: bresp=%b required 00", r); end
    exp_q.push_back({RESP_OKAY, 32'h0});
    axi_read(6'h0C, d, r); e = exp_q.pop_front(); asserts++;
    if ({r, d} !== e) begin failures++; $display("FAIL irq_stat_off: got %h required %h", {r, d}, e); end
`endif
  endtask

  initial begin
    bus.awaddr = '0; bus.awprot = 3'b0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = 4'hF; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = 3'b0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    for (int i = 0; i < NUM_DICE; i++) ev[i] = 1;
    test_reset();
    test_single_roll();
    test_restart();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_roll();
    test_irq();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

`default_nettype wire
